// File: rtl/miner_job_sched_pkg.sv
// Shared types and widths for the miner job scheduler.
// Holds the scheduler state enum and bus widths.
package miner_job_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      FEED,
      CHECK,
      REPORT
   } sched_state_t;

   localparam int NONCE_BYTE_LEN = 24;
   localparam int NONCE_W = 8 * NONCE_BYTE_LEN;
   localparam int HASH_W = 256;
   localparam int WORD_W = 32;
   localparam int BNUM_W = 11;

endpackage

// File: rtl/miner_job_sched_if.sv
// Scheduler <-> Miner core bus.
// master = scheduler side, slave = miner side.
interface miner_job_sched_if #(
   parameter int NW = miner_job_sched_pkg::NONCE_W
);

   logic                                      Mnr_Update_O;
   logic [miner_job_sched_pkg::WORD_W-1:0]    Mnr_Msg_O;
   logic [miner_job_sched_pkg::BNUM_W-1:0]    Mnr_ByteNum_O;
   logic [NW-1:0]                             Mnr_Nonce_O;
   logic                                      Mnr_Next_I;
   logic                                      Mnr_Vld_I;
   logic                                      Mnr_Rdy_I;
   logic [miner_job_sched_pkg::HASH_W-1:0]    Mnr_Hash_I;

   modport master (
      output Mnr_Update_O,
      output Mnr_Msg_O,
      output Mnr_ByteNum_O,
      output Mnr_Nonce_O,
      input  Mnr_Next_I,
      input  Mnr_Vld_I,
      input  Mnr_Rdy_I,
      input  Mnr_Hash_I
   );

   modport slave (
      input  Mnr_Update_O,
      input  Mnr_Msg_O,
      input  Mnr_ByteNum_O,
      input  Mnr_Nonce_O,
      output Mnr_Next_I,
      output Mnr_Vld_I,
      output Mnr_Rdy_I,
      output Mnr_Hash_I
   );

endinterface

// File: rtl/miner_hdr_ram.sv
// Header word store for the miner scheduler.
// One synchronous write port, one asynchronous read port.
module miner_hdr_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
)(
   input  logic          Clk,
   input  logic          We_i,
   input  logic [AW-1:0] WAddr_i,
   input  logic [31:0]   WData_i,
   input  logic [AW-1:0] RAddr_i,
   output logic [31:0]   RData_o
);

   logic [31:0] mem_q [DEPTH];

   // Header words are written by the host while the scheduler is idle
   always_ff @(posedge Clk) begin
      if (We_i) mem_q[WAddr_i] <= WData_i;
   end

   assign RData_o = mem_q[RAddr_i];

endmodule

// File: rtl/miner_job_sched.sv
// Job scheduler: relaunches one Miner core with successive nonces.
// Optional watchdog enabled by defining MINER_SCHED_TIMEOUT_EN.
module miner_job_sched
   import miner_job_sched_pkg::*;
#(
   parameter int NONCE_BYTE_LEN = 24,
   parameter int HDR_WORDS      = 256,
   parameter int NONCE_STRIDE   = 1,
   parameter int TIMEOUT_CYC    = 65535
)(
   input  logic                      Clk,
   input  logic                      Rst_n,
   input  logic                      Hdr_We_I,
   input  logic [7:0]                Hdr_Addr_I,
   input  logic [WORD_W-1:0]         Hdr_Data_I,
   input  logic                      Job_Vld_I,
   output logic                      Job_Rdy_O,
   input  logic [8*NONCE_BYTE_LEN-1:0] Job_Nonce_I,
   input  logic [BNUM_W-1:0]         Job_ByteNum_I,
   input  logic [31:0]               Job_MaxIter_I,
   input  logic                      Abort_I,
   miner_job_sched_if.master         mnr,
   output logic                      Res_Vld_O,
   input  logic                      Res_Ack_I,
   output logic                      Res_Found_O,
   output logic                      Res_Timeout_O,
   output logic [8*NONCE_BYTE_LEN-1:0] Res_Nonce_O,
   output logic [HASH_W-1:0]         Res_Hash_O,
   output logic [31:0]               Iter_Cnt_O
);

   localparam int NW = 8 * NONCE_BYTE_LEN;
   localparam int AW = $clog2(HDR_WORDS);
   localparam logic [AW-1:0] PTR_MAX = AW'(HDR_WORDS - 1);

   sched_state_t      state_q, state_d;
   logic [NW-1:0]     nonce_q, nonce_d;
   logic [BNUM_W-1:0] bnum_q, bnum_d;
   logic [31:0]       maxit_q, maxit_d;
   logic [31:0]       iter_q, iter_d;
   logic              rdy_q, rdy_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [NW-1:0]     rnonce_q, rnonce_d;
   logic [HASH_W-1:0] rhash_q, rhash_d;
   logic              found_q, found_d;
   logic              tout_q, tout_d;
   logic              upd;
   logic              hdr_we;
   logic              rdy_edge;
`ifdef MINER_SCHED_TIMEOUT_EN
   logic [31:0]       cyc_q, cyc_d;
`endif

   assign rdy_edge = mnr.Mnr_Rdy_I && !rdy_q;

   miner_hdr_ram #(
      .DEPTH (HDR_WORDS),
      .AW    (AW)
   ) u_hdr (
      .Clk     (Clk),
      .We_i    (hdr_we),
      .WAddr_i (Hdr_Addr_I[AW-1:0]),
      .WData_i (Hdr_Data_I),
      .RAddr_i (rptr_q),
      .RData_o (mnr.Mnr_Msg_O)
   );

   // Next-state, datapath updates and Moore outputs of the scheduler
   always_comb begin
      state_d  = state_q;
      nonce_d  = nonce_q;
      bnum_d   = bnum_q;
      maxit_d  = maxit_q;
      iter_d   = iter_q;
      rdy_d    = rdy_q;
      rptr_d   = rptr_q;
      rnonce_d = rnonce_q;
      rhash_d  = rhash_q;
      found_d  = found_q;
      tout_d   = tout_q;
      upd      = 1'b0;
      hdr_we   = Hdr_We_I && (state_q == IDLE);
`ifdef MINER_SCHED_TIMEOUT_EN
      cyc_d    = cyc_q;
`endif
      if (state_q != IDLE && Abort_I) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (Job_Vld_I) begin
                  nonce_d = Job_Nonce_I;
                  bnum_d  = Job_ByteNum_I;
                  maxit_d = Job_MaxIter_I;
                  iter_d  = '0;
                  state_d = START;
               end
            end
            START: begin
               upd     = 1'b1;
               rptr_d  = '0;
               rdy_d   = 1'b0;
`ifdef MINER_SCHED_TIMEOUT_EN
               cyc_d   = '0;
`endif
               state_d = FEED;
            end
            FEED: begin
               rdy_d = mnr.Mnr_Rdy_I;
               if (mnr.Mnr_Next_I && rptr_q != PTR_MAX)
                  rptr_d = rptr_q + 1'b1;
`ifdef MINER_SCHED_TIMEOUT_EN
               cyc_d = cyc_q + 32'd1;
`endif
               if (rdy_edge) begin
                  state_d = CHECK;
`ifdef MINER_SCHED_TIMEOUT_EN
               end else if (cyc_q == 32'(TIMEOUT_CYC - 1)) begin
                  rnonce_d = nonce_q;
                  rhash_d  = mnr.Mnr_Hash_I;
                  found_d  = 1'b0;
                  tout_d   = 1'b1;
                  state_d  = REPORT;
`endif
               end
            end
            CHECK: begin
               rnonce_d = nonce_q;
               rhash_d  = mnr.Mnr_Hash_I;
               iter_d   = iter_q + 32'd1;
               if (mnr.Mnr_Vld_I) begin
                  found_d = 1'b1;
                  tout_d  = 1'b0;
                  state_d = REPORT;
               end else if (maxit_q != '0 && iter_d == maxit_q) begin
                  found_d = 1'b0;
                  tout_d  = 1'b0;
                  state_d = REPORT;
               end else begin
                  nonce_d = nonce_q + NW'(NONCE_STRIDE);
                  state_d = START;
               end
            end
            REPORT: begin
               if (Res_Ack_I) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         nonce_q  <= '0;
         bnum_q   <= '0;
         maxit_q  <= '0;
         iter_q   <= '0;
         rdy_q    <= 1'b0;
         rptr_q   <= '0;
         rnonce_q <= '0;
         rhash_q  <= '0;
         found_q  <= 1'b0;
         tout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         nonce_q  <= nonce_d;
         bnum_q   <= bnum_d;
         maxit_q  <= maxit_d;
         iter_q   <= iter_d;
         rdy_q    <= rdy_d;
         rptr_q   <= rptr_d;
         rnonce_q <= rnonce_d;
         rhash_q  <= rhash_d;
         found_q  <= found_d;
         tout_q   <= tout_d;
      end
   end

`ifdef MINER_SCHED_TIMEOUT_EN
   // Watchdog cycle counter for the current iteration
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) cyc_q <= '0;
      else        cyc_q <= cyc_d;
   end
   assign Res_Timeout_O = tout_q;
`else
   assign Res_Timeout_O = 1'b0;
`endif

   assign Job_Rdy_O         = (state_q == IDLE);
   assign Res_Vld_O         = (state_q == REPORT);
   assign Res_Found_O       = found_q;
   assign Res_Nonce_O       = rnonce_q;
   assign Res_Hash_O        = rhash_q;
   assign Iter_Cnt_O        = iter_q;
   assign mnr.Mnr_Update_O  = upd;
   assign mnr.Mnr_ByteNum_O = bnum_q;
   assign mnr.Mnr_Nonce_O   = nonce_q;

endmodule

// File: tb/tb_miner_job_sched.sv
// Self-checking bench for miner_job_sched.
// Behavioural miner responder plus job-level expectation model.
module tb_miner_job_sched;

   localparam int NW = 192;

   logic            Clk = 1'b0;
   logic            Rst_n;
   logic            Hdr_We_I;
   logic [7:0]      Hdr_Addr_I;
   logic [31:0]     Hdr_Data_I;
   logic            Job_Vld_I;
   logic            Job_Rdy_O;
   logic [NW-1:0]   Job_Nonce_I;
   logic [10:0]     Job_ByteNum_I;
   logic [31:0]     Job_MaxIter_I;
   logic            Abort_I;
   logic            Res_Vld_O;
   logic            Res_Ack_I;
   logic            Res_Found_O;
   logic            Res_Timeout_O;
   logic [NW-1:0]   Res_Nonce_O;
   logic [255:0]    Res_Hash_O;
   logic [31:0]     Iter_Cnt_O;

   miner_job_sched_if #(.NW(NW)) mnr ();

   miner_job_sched #(
      .NONCE_BYTE_LEN (24),
      .HDR_WORDS      (256),
      .NONCE_STRIDE   (1),
      .TIMEOUT_CYC    (100)
   ) dut (
      .Clk           (Clk),
      .Rst_n         (Rst_n),
      .Hdr_We_I      (Hdr_We_I),
      .Hdr_Addr_I    (Hdr_Addr_I),
      .Hdr_Data_I    (Hdr_Data_I),
      .Job_Vld_I     (Job_Vld_I),
      .Job_Rdy_O     (Job_Rdy_O),
      .Job_Nonce_I   (Job_Nonce_I),
      .Job_ByteNum_I (Job_ByteNum_I),
      .Job_MaxIter_I (Job_MaxIter_I),
      .Abort_I       (Abort_I),
      .mnr           (mnr),
      .Res_Vld_O     (Res_Vld_O),
      .Res_Ack_I     (Res_Ack_I),
      .Res_Found_O   (Res_Found_O),
      .Res_Timeout_O (Res_Timeout_O),
      .Res_Nonce_O   (Res_Nonce_O),
      .Res_Hash_O    (Res_Hash_O),
      .Iter_Cnt_O    (Iter_Cnt_O)
   );

   always #5 Clk = ~Clk;

   int            total = 0;
   int            passed = 0;
   logic [31:0]   hdr_m [256];
   logic [NW-1:0] upd_q [$];
   int            job_upd = 0;
   int            find_at = 0;
   bit            abort_on_edge = 1'b0;
   bit            hang = 1'b0;

   task automatic check(input string tag, input logic [255:0] obs,
                        input logic [255:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [255:0] hfun(input logic [NW-1:0] n);
      return {n[63:0] ^ 64'hdead_beef_0123_4567, ~n[191:128],
              n[127:64], 64'hc0ff_ee00 + {32'd0, n[31:0]}};
   endfunction

   // Miner responder: drops Rdy on Update, consumes words, raises Rdy
   initial begin
      logic [NW-1:0] cn;
      int            len;
      int            ptr;
      mnr.Mnr_Next_I = 1'b0;
      mnr.Mnr_Rdy_I  = 1'b1;
      mnr.Mnr_Vld_I  = 1'b0;
      mnr.Mnr_Hash_I = '0;
      forever begin
         @(posedge Clk); #1;
         if (Rst_n && mnr.Mnr_Update_O) begin
            cn = mnr.Mnr_Nonce_O;
            upd_q.push_back(cn);
            job_upd++;
            mnr.Mnr_Rdy_I = 1'b0;
            mnr.Mnr_Vld_I = 1'b0;
            len = $urandom_range(2, 6);
            ptr = 0;
            @(posedge Clk); #1;
            check("upd_width", {255'd0, mnr.Mnr_Update_O}, 256'd0);
            for (int i = 0; i < len; i++) begin
               if (i > 0) begin
                  @(posedge Clk); #1;
               end
               check("msg", {224'd0, mnr.Mnr_Msg_O}, {224'd0, hdr_m[ptr]});
               mnr.Mnr_Next_I = 1'($urandom_range(0, 1));
               if (mnr.Mnr_Next_I) ptr++;
            end
            @(posedge Clk); #1;
            mnr.Mnr_Next_I = 1'b0;
            if (!hang) begin
               mnr.Mnr_Rdy_I  = 1'b1;
               mnr.Mnr_Vld_I  = (find_at != 0 && job_upd == find_at);
               mnr.Mnr_Hash_I = hfun(cn);
               if (abort_on_edge) begin
                  Abort_I = 1'b1;
                  @(posedge Clk); #1;
                  Abort_I = 1'b0;
                  abort_on_edge = 1'b0;
               end
            end
         end
      end
   end

   task automatic start_job(input logic [NW-1:0] n, input int mx,
                            input int f, input bit poke);
      job_upd = 0;
      find_at = f;
      upd_q.delete();
      Job_Nonce_I   = n;
      Job_ByteNum_I = 11'd64;
      Job_MaxIter_I = mx;
      Job_Vld_I     = 1'b1;
      @(posedge Clk); #1;
      Job_Vld_I = 1'b0;
      check("upd_latency", {255'd0, mnr.Mnr_Update_O}, 256'd1);
      check("bytenum", {245'd0, mnr.Mnr_ByteNum_O}, 256'd64);
      if (poke) begin
         @(posedge Clk); #1;
         Hdr_We_I   = 1'b1;
         Hdr_Addr_I = 8'd0;
         Hdr_Data_I = ~hdr_m[0];
         Job_Vld_I  = 1'b1;
         Job_Nonce_I = ~n;
         check("rdy_busy", {255'd0, Job_Rdy_O}, 256'd0);
         @(posedge Clk); #1;
         Hdr_We_I  = 1'b0;
         Job_Vld_I = 1'b0;
      end
   endtask

   task automatic run_job(input logic [NW-1:0] n, input int mx,
                          input int f, input bit poke);
      bit            fnd;
      int            iters;
      int            c;
      logic [NW-1:0] en;
      fnd   = (f != 0) && (mx == 0 || f <= mx);
      iters = fnd ? f : mx;
      start_job(n, mx, f, poke);
      c = 0;
      while (!Res_Vld_O && c < 3000) begin
         @(posedge Clk); #1;
         c++;
      end
      check("res_wait", {255'd0, Res_Vld_O}, 256'd1);
      en = n + NW'(iters - 1);
      check("found", {255'd0, Res_Found_O}, {255'd0, fnd});
      check("timeout", {255'd0, Res_Timeout_O}, 256'd0);
      check("iter_cnt", {224'd0, Iter_Cnt_O}, 256'(iters));
      check("res_nonce", {64'd0, Res_Nonce_O}, {64'd0, en});
      check("res_hash", Res_Hash_O, hfun(en));
      check("n_updates", 256'(upd_q.size()), 256'(iters));
      for (int k = 0; k < upd_q.size() && k < iters; k++)
         check("upd_nonce", {64'd0, upd_q[k]}, {64'd0, n + NW'(k)});
      @(posedge Clk); #1;
      check("res_hold", {255'd0, Res_Vld_O}, 256'd1);
      Res_Ack_I = 1'b1;
      @(posedge Clk); #1;
      Res_Ack_I = 1'b0;
      check("res_clr", {255'd0, Res_Vld_O}, 256'd0);
      check("rdy_idle", {255'd0, Job_Rdy_O}, 256'd1);
   endtask

   initial begin
      logic [NW-1:0] n;
      int            mx;
      int            f;
      int            c;
      Rst_n = 1'b0;
      Hdr_We_I = 1'b0;
      Hdr_Addr_I = '0;
      Hdr_Data_I = '0;
      Job_Vld_I = 1'b0;
      Job_Nonce_I = '0;
      Job_ByteNum_I = '0;
      Job_MaxIter_I = '0;
      Abort_I = 1'b0;
      Res_Ack_I = 1'b0;
      for (int i = 0; i < 256; i++) hdr_m[i] = '0;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_rdy", {255'd0, Job_Rdy_O}, 256'd1);
      check("rst_vld", {255'd0, Res_Vld_O}, 256'd0);
      check("rst_upd", {255'd0, mnr.Mnr_Update_O}, 256'd0);
      check("rst_found", {255'd0, Res_Found_O}, 256'd0);
      check("rst_tout", {255'd0, Res_Timeout_O}, 256'd0);
      check("rst_iter", {224'd0, Iter_Cnt_O}, 256'd0);
      check("rst_rnonce", {64'd0, Res_Nonce_O}, 256'd0);
      check("rst_hash", Res_Hash_O, 256'd0);
      check("rst_mnonce", {64'd0, mnr.Mnr_Nonce_O}, 256'd0);
      check("rst_bnum", {245'd0, mnr.Mnr_ByteNum_O}, 256'd0);
      Rst_n = 1'b1;
      @(posedge Clk); #1;

      // 40-byte header = 10 words, plus a few spare words
      for (int i = 0; i < 16; i++) begin
         hdr_m[i]   = $urandom;
         Hdr_We_I   = 1'b1;
         Hdr_Addr_I = 8'(i);
         Hdr_Data_I = hdr_m[i];
         @(posedge Clk); #1;
      end
      Hdr_We_I = 1'b0;

      n = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_job(n, 0, 1, 1'b0);
      n = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_job(n, 3, 0, 1'b0);
      n = '1;
      run_job(n, 0, 2, 1'b0);

      // Abort on the very cycle the miner reports a hit
      abort_on_edge = 1'b1;
      start_job(192'h1234, 0, 1, 1'b0);
      c = 0;
      while (abort_on_edge && c < 200) begin
         @(posedge Clk); #1;
         c++;
      end
      check("abort_seen", {255'd0, abort_on_edge}, 256'd0);
      for (int i = 0; i < 5; i++) begin
         check("abort_novld", {255'd0, Res_Vld_O}, 256'd0);
         @(posedge Clk); #1;
      end
      check("abort_idle", {255'd0, Job_Rdy_O}, 256'd1);
      check("abort_upd", 256'(upd_q.size()), 256'd1);

      // Header write and job request while busy must be ignored
      n = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_job(n, 0, 3, 1'b1);
      n = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_job(n, 0, 1, 1'b0);

      for (int j = 0; j < 6; j++) begin
         n  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         mx = $urandom_range(0, 4);
         f  = $urandom_range(0, 5);
         if (mx == 0 && f == 0) f = 1;
         run_job(n, mx, f, 1'b0);
      end

`ifdef MINER_SCHED_TIMEOUT_EN
      hang = 1'b1;
      n = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      start_job(n, 0, 0, 1'b0);
      c = 0;
      while (!Res_Vld_O && c < 500) begin
         @(posedge Clk); #1;
         c++;
      end
      check("wd_latency", 256'(c), 256'd101);
      check("wd_tout", {255'd0, Res_Timeout_O}, 256'd1);
      check("wd_found", {255'd0, Res_Found_O}, 256'd0);
      check("wd_nonce", {64'd0, Res_Nonce_O}, {64'd0, n});
      Res_Ack_I = 1'b1;
      @(posedge Clk); #1;
      Res_Ack_I = 1'b0;
      hang = 1'b0;
`endif

      repeat (3) @(posedge Clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
